debounce_event_arbiter: RTL and testbench



---
 rtl/debounce_event_arbiter.sv | 114 +++++++++++
 tb/tb_debounce_event_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : debounce_event_arbiter
// Description : Serializes level changes from N debounced switch channels onto
//               one registered valid/ready event stream (round-robin grant).
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_event_arbiter #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  db_level,
    output logic          ev_valid,
    input  logic          ev_ready,
    output logic [CW-1:0] ev_chan,
    output logic          ev_level,
    output logic [N-1:0]  ovf,
    input  logic          ovf_clr
);

    localparam logic [CW-1:0] c_PTR_RST = CW'(N - 1);

    logic [N-1:0]  r_prev;
    logic          r_armed;
    logic [N-1:0]  r_pend;
    logic [N-1:0]  r_plvl;
    logic [CW-1:0] r_ptr;
    logic          r_ev_valid;
    logic [CW-1:0] r_ev_chan;
    logic          r_ev_level;
    logic [N-1:0]  r_ovf;

    logic [N-1:0]  w_chg;
    logic          w_load;
    logic          w_found;
    logic [CW-1:0] w_win;
    logic [N-1:0]  w_grant;

    assign w_chg  = {N{r_armed}} & (db_level ^ r_prev);
    assign w_load = (!r_ev_valid || ev_ready) && (|r_pend);

    // Search starts just after the last granted channel and wraps inside 0..N-1.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (int'(r_ptr) + k) % N;
            if (!w_found && r_pend[j[CW-1:0]]) begin
                w_found = 1'b1;
                w_win   = j[CW-1:0];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
            w_grant[i] = w_load && (w_win == CW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
            r_pend  <= '0;
            r_plvl  <= '0;
            r_ovf   <= '0;
        end else begin
            r_prev  <= db_level;
            r_armed <= 1'b1;
            for (int i = 0; i < N; i++) begin
                // A change landing on the granted channel re-arms it without loss.
                if (w_chg[i]) begin
                    r_pend[i] <= 1'b1;
                    r_plvl[i] <= db_level[i];
                end else if (w_grant[i]) begin
                    r_pend[i] <= 1'b0;
                end
                if (w_chg[i] && r_pend[i] && !w_grant[i]) begin
                    r_ovf[i] <= 1'b1;
                end else if (ovf_clr) begin
                    r_ovf[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ev_valid <= 1'b0;
            r_ev_chan  <= '0;
            r_ev_level <= 1'b0;
            r_ptr      <= c_PTR_RST;
        end else if (w_load) begin
            r_ev_valid <= 1'b1;
            r_ev_chan  <= w_win;
            r_ev_level <= r_plvl[w_win];
            r_ptr      <= w_win;
        end else if (ev_ready) begin
            r_ev_valid <= 1'b0;
        end
    end

    assign ev_valid = r_ev_valid;
    assign ev_chan  = r_ev_chan;
    assign ev_level = r_ev_level;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_debounce_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_event_arbiter
// Description : Scoreboard bench: reference model predicts events, monitor
//               compares presented events, ev_valid and ovf each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_event_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  db_level = '0;
    logic          ev_valid;
    logic          ev_ready = 1'b1;
    logic [CW-1:0] ev_chan;
    logic          ev_level;
    logic [N-1:0]  ovf;
    logic          ovf_clr = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_event_arbiter #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .db_level (db_level),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_chan  (ev_chan),
        .ev_level (ev_level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #10 clk = ~clk;

    // Reference model state: each channel remembers its newest unserved level.
    bit       m_prev [N];
    bit       m_pend [N];
    bit       m_plvl [N];
    bit       m_ovf  [N];
    bit       m_armed;
    int       m_last;
    bit       m_valid;
    bit [CW:0] exp_q[$];

    function automatic bit [N-1:0] m_ovf_vec();
        bit [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_ovf[i];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_plvl[i] = 0; m_ovf[i] = 0;
            end
            m_armed = 0;
            m_last  = N - 1;
            m_valid = 0;
            exp_q.delete();
        end else begin
            bit chg [N];
            bit any;
            bit load;
            int win;
            any = 0;
            for (int i = 0; i < N; i++) begin
                chg[i] = m_armed && (db_level[i] != m_prev[i]);
                any |= m_pend[i];
            end
            load = (!m_valid || ev_ready) && any;
            win  = -1;
            if (load) begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_last + k) % N;
                    if (win < 0 && m_pend[j]) win = j;
                end
            end
            if (m_valid && ev_ready) m_valid = 0;
            if (load) begin
                exp_q.push_back({win[CW-1:0], m_plvl[win]});
                m_valid = 1;
                m_last  = win;
            end
            for (int i = 0; i < N; i++) begin
                if (chg[i] && m_pend[i] && i != win) m_ovf[i] = 1;
                else if (ovf_clr) m_ovf[i] = 0;
                if (i == win) m_pend[i] = 0;
                if (chg[i]) begin
                    m_pend[i] = 1;
                    m_plvl[i] = db_level[i];
                end
                m_prev[i] = db_level[i];
            end
            m_armed = 1;
        end
    end

    // Monitor: checks the presented event against the scoreboard head.
    always @(negedge clk) begin
        n_cmp++;
        if (ev_valid !== m_valid) begin
            n_bad++;
            $display("FAIL valid: got %b want %b at %0t", ev_valid, m_valid, $time);
        end
        n_cmp++;
        if (ovf !== m_ovf_vec()) begin
            n_bad++;
            $display("FAIL ovf: got %b want %b at %0t", ovf, m_ovf_vec(), $time);
        end
        if (ev_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL event: got ch%0d lvl%0d want none at %0t", ev_chan, ev_level, $time);
            end else if ({ev_chan, ev_level} !== exp_q[0]) begin
                n_bad++;
                $display("FAIL event: got ch%0d lvl%0d want ch%0d lvl%0d at %0t",
                         ev_chan, ev_level, exp_q[0][CW:1], exp_q[0][0], $time);
            end
            if (ev_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic toggle(input bit [N-1:0] m);
        db_level = db_level ^ m;
    endtask

    initial begin
        // Levels high at reset must not produce events.
        db_level = 4'b1010;
        ev_ready = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(10);

        // Single press/release on ch2.
        toggle(4'b0100); tick(5);
        toggle(4'b0100); tick(5);

        // Round-robin, then wrap from ptr = 3.
        ev_ready = 1'b0;
        toggle(4'b1011); tick(3);
        ev_ready = 1'b1; tick(5);
        toggle(4'b0011); tick(5);

        // Backpressure: held output, next toggle only pends.
        ev_ready = 1'b0;
        toggle(4'b1000); tick(3);
        toggle(4'b1000); tick(20);
        toggle(4'b0100); tick(1);
        ev_ready = 1'b1; tick(5);

        // Overflow on ch1, clear, then clear coincident with a new overflow.
        ev_ready = 1'b0;
        toggle(4'b0001); tick(3);
        toggle(4'b0010); tick(1);
        toggle(4'b0010); tick(2);
        ev_ready = 1'b1; tick(4);
        ovf_clr = 1'b1; tick(1);
        ovf_clr = 1'b0; tick(2);
        ev_ready = 1'b0;
        toggle(4'b0100); tick(3);
        toggle(4'b1000); tick(1);
        toggle(4'b1000); ovf_clr = 1'b1; tick(1);
        ovf_clr = 1'b0;
        ev_ready = 1'b1; tick(5);

        // Asynchronous reset while an event is presented and two are pending.
        ev_ready = 1'b0;
        toggle(4'b0001); tick(3);
        toggle(4'b0110); tick(1);
        #3 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ev_valid !== 1'b0 || ev_chan !== '0 || ev_level !== 1'b0 || ovf !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got v%b ch%0d l%b ovf%b want all zero",
                     ev_valid, ev_chan, ev_level, ovf);
        end
        tick(2);
        reset_n = 1'b1;
        ev_ready = 1'b1;
        tick(10);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit [N-1:0] m;
            m = '0;
            for (int i = 0; i < N; i++) m[i] = ($urandom_range(0, 9) == 0);
            toggle(m);
            ev_ready = ($urandom_range(0, 3) != 0);
            ovf_clr  = ($urandom_range(0, 31) == 0);
            tick(1);
        end
        ovf_clr  = 1'b0;
        ev_ready = 1'b1;
        tick(20);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d events outstanding want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
